// File: rtl/async_fifo_wr_ctrl.sv
// async_fifo_wr_ctrl: write-side pointer, read-pointer synchroniser and flags for a dual-clock FIFO
module async_fifo_wr_ctrl #(
    parameter int DEPTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int AF_THRESH   = DEPTH - 2
) (
    input  logic                       w_clk,
    input  logic                       w_rst,
    input  logic                       w_inc,
    input  logic                       w_ovf_clr,
    input  logic [$clog2(DEPTH):0]     r_gray_ptr,
    output logic                       w_en,
    output logic [$clog2(DEPTH)-1:0]   w_addr,
    output logic [$clog2(DEPTH):0]     w_gray_ptr,
    output logic                       w_full,
    output logic                       w_almost_full,
    output logic [$clog2(DEPTH):0]     w_level,
    output logic                       w_overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] AF_T = AF_THRESH[AW:0];

    logic [SYNC_STAGES-1:0][AW:0] sync_q;
    logic [AW:0] rq, r_bin_s, w_bin, bin_next, gray_next, level_next;

    assign rq         = sync_q[SYNC_STAGES-1];
    assign w_en       = w_inc & ~w_full;
    assign w_addr     = w_bin[AW-1:0];
    assign bin_next   = w_bin + {{AW{1'b0}}, w_en};
    assign gray_next  = bin_next ^ (bin_next >> 1);
    assign level_next = bin_next - r_bin_s;

    // Gray-to-binary of the synchronised read pointer: bit i is the XOR of all bits at or above i
    always_comb begin
        for (int i = 0; i <= AW; i++) r_bin_s[i] = ^(rq >> i);
    end

    // Plain flop chain bringing the read Gray pointer into w_clk; nothing combinational in front
    always_ff @(posedge w_clk or negedge w_rst) begin
        if (!w_rst) sync_q <= '0;
        else        sync_q <= {sync_q[SYNC_STAGES-2:0], r_gray_ptr};
    end

    // Pointers and flags all derive from bin_next so Gray, full and level never lag the binary pointer
    always_ff @(posedge w_clk or negedge w_rst) begin
        if (!w_rst) begin
            w_bin         <= '0;
            w_gray_ptr    <= '0;
            w_full        <= 1'b0;
            w_almost_full <= 1'b0;
            w_level       <= '0;
            w_overflow    <= 1'b0;
        end else begin
            w_bin         <= bin_next;
            w_gray_ptr    <= gray_next;
            w_full        <= gray_next == {~rq[AW:AW-1], rq[AW-2:0]};
            w_almost_full <= level_next >= AF_T;
            w_level       <= level_next;
            w_overflow    <= (w_inc & w_full) | (w_overflow & ~w_ovf_clr);
        end
    end
endmodule

// File: doc/async_fifo_wr_ctrl.md
Name: async_fifo_wr_ctrl

Overview:
Write-domain controller for the dual-clock FIFO. It holds the binary and Gray write pointers and synchronises the read-domain Gray pointer into w_clk. It generates registered full, almost-full, fill-level and sticky overflow flags for any power-of-two depth. Gray conversion is arithmetic (no lookup), and the Gray pointer updates in the same cycle as the binary pointer. It sits between the write-side client and the FIFO dual-port RAM, with its Gray pointer crossing to the read controller.

Parameters:
DEPTH, 8, FIFO entries; power of two, >= 4
SYNC_STAGES, 2, flops in the read-pointer synchroniser; >= 2
AF_THRESH, DEPTH-2, fill level at or above which w_almost_full asserts; 1..DEPTH

Ports:
w_clk  in  1  write clock
w_rst  in  1  asynchronous active-low reset
w_inc  in  1  write request from client
w_ovf_clr  in  1  synchronous clear of w_overflow
r_gray_ptr  in  AW+1  read Gray pointer, read-clock domain (AW = $clog2(DEPTH))
w_en  out  1  RAM write strobe = w_inc & ~w_full (combinational)
w_addr  out  AW  RAM write address = w_bin[AW-1:0]
w_gray_ptr  out  AW+1  registered Gray write pointer, to read domain
w_full  out  1  registered full flag
w_almost_full  out  1  registered, level >= AF_THRESH
w_level  out  AW+1  registered conservative occupancy, 0..DEPTH
w_overflow  out  1  sticky: write attempted while full

Behaviour:
- Reset (w_rst low, asynchronous): all of the following go to 0 immediately, regardless of clock:
  - w_bin, w_gray_ptr, all synchroniser flops
  - w_full, w_almost_full, w_level, w_overflow
- Synchroniser: r_gray_ptr passes through SYNC_STAGES flops to give rq. No logic sits before the first flop.
- Synced read binary: r_bin_s = gray2bin(rq), combinational.
- Accept: w_en = w_inc & ~w_full.
- On accept:
  - bin_next = w_bin + 1, modulo 2^(AW+1).
  - Otherwise bin_next = w_bin.
- Gray: gray_next = bin_next ^ (bin_next >> 1). w_gray_ptr <= gray_next every cycle, so it is never stale relative to w_bin.
- Full: w_full <= (gray_next == {~rq[AW:AW-1], rq[AW-2:0]}).
  - Deasserts no earlier than SYNC_STAGES+1 w_clk edges after r_gray_ptr advances.
  - Asserts on the same edge that accepts the DEPTH-th outstanding write.
- Level: w_level <= (bin_next - r_bin_s) mod 2^(AW+1).
  - Never exceeds DEPTH.
  - Overestimates true occupancy by in-flight reads (safe direction).
- Almost-full: w_almost_full <= (level_next >= AF_THRESH), same edge as w_level.
- Overflow: set on any edge where w_inc & w_full.
  - Cleared by w_ovf_clr when no new violation occurs on that edge.
  - A simultaneous set and clear leaves w_overflow set.
- Write while full: w_en = 0; w_bin, w_addr and w_gray_ptr hold; no RAM write.
- Wrap-around:
  - w_addr wraps DEPTH-1 -> 0.
  - The pointer MSB toggles every DEPTH accepts.
  - w_gray_ptr changes exactly one bit per accept, including the 2^(AW+1)-1 -> 0 transition.
- Simultaneous write and read-pointer advance: a write accepted on an edge where full is cleared by the newly synced rq is legal. Full is recomputed from gray_next and the new rq.
- Reset mid-operation: outputs clear immediately and asynchronously. The first accept after release writes w_addr = 0. The read domain must be reset together with this block (system requirement; not checked here).
- Gray values of r_gray_ptr that skip codes (metastability) resolve conservatively: full holds until a valid advance is seen.

Test Plan:
- Reset, DEPTH=8, r_gray_ptr=0, 8 consecutive w_inc -> w_addr 0..7, w_gray_ptr 0001,0011,0010,0110,0111,0101,0100,1100; w_full=1 after the 8th accept edge; w_level=8.
- Full, w_inc=1 for 3 cycles -> w_en=0, w_addr stays 0, w_gray_ptr stays 1100, w_overflow=1 and stays 1; w_ovf_clr=1 with w_inc=0 -> w_overflow=0 next edge.
- Full, drive r_gray_ptr=0001 -> w_full=0 and w_level=7 exactly 3 edges later (SYNC_STAGES=2); one write -> w_full=1 again, w_addr was 0.
- AF_THRESH=6, from empty write 6 -> w_almost_full rises on 6th accept edge; r_gray_ptr=0011 (2 read) -> falls 3 edges later with w_level=4.
- Continuous write with r_gray_ptr tracking w_gray_ptr (delayed 1 cycle), 40 writes -> w_full never set; each w_gray_ptr transition changes exactly 1 bit, including 1000->0000.
- Assert w_rst low mid-burst at w_addr=5, asynchronously, between edges -> all outputs 0 before the next edge; after release the first write has w_addr=0 and w_gray_ptr=0001.
